// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: drives memory_access with setup/hold around ENABLE,
// captures the READ word on HANDSHAKE and presents it to writeback.
module mem_stage_ctrl #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STAGE_VALID,
  input  logic [2:0]  STAGE_CTRL,
  input  logic [31:0] STAGE_ADDR,
  input  logic [47:0] STAGE_ALU,
  input  logic [3:0]  STAGE_RD,
  output logic        STALL,
  output logic        MEM_ENABLE,
  output logic [2:0]  MEM_CTRL,
  output logic [31:0] MEM_ADDRESS,
  input  logic [47:0] MEM_READ,
  input  logic        MEM_HANDSHAKE,
  output logic        WB_VALID,
  input  logic        WB_READY,
  output logic [47:0] WB_DATA,
  output logic [3:0]  WB_RD,
  output logic        ERROR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_DONE
  } state_t;

  // SETUP leaves after SETUP_CYCLES+1 edges so the bus has been stable for
  // at least SETUP_CYCLES full cycles when ENABLE rises.
  localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYCLES);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;

  // NOTE: every output is a flop written here with <=, so all of them update
  // together on the edge and no combinational path reaches the ports.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      STALL       <= 1'b0;
      MEM_ENABLE  <= 1'b0;
      MEM_CTRL    <= 3'b000;
      MEM_ADDRESS <= '0;
      WB_VALID    <= 1'b0;
      WB_DATA     <= '0;
      WB_RD       <= '0;
      ERROR       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (STAGE_VALID) begin
            STALL <= 1'b1;
            if (STAGE_CTRL[2]) begin
              MEM_CTRL    <= STAGE_CTRL;
              MEM_ADDRESS <= STAGE_ADDR;
              WB_RD       <= STAGE_RD;
              cnt         <= '0;
              state       <= ST_SETUP;
            end else begin
              WB_DATA  <= STAGE_ALU;
              WB_RD    <= STAGE_RD;
              WB_VALID <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end

        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            MEM_ENABLE <= 1'b1;
            cnt        <= '0;
            state      <= ST_WAIT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_WAIT: begin
          // A handshake on the final timeout cycle still delivers real data.
          if (MEM_HANDSHAKE) begin
            WB_DATA    <= MEM_READ;
            WB_VALID   <= 1'b1;
            MEM_ENABLE <= 1'b0;
            state      <= ST_DONE;
          end else if (cnt == TIMEOUT_LAST) begin
            ERROR      <= 1'b1;
            WB_DATA    <= '0;
            WB_VALID   <= 1'b1;
            MEM_ENABLE <= 1'b0;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_DONE: begin
          if (WB_READY) begin
            WB_VALID <= 1'b0;
            STALL    <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          STALL <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: the stimulus thread pushes expected
// writeback words; a negedge monitor pops and compares whenever WB_VALID shows.
module tb_mem_stage_ctrl;

  localparam int unsigned SETUP_CYCLES = 2;
  localparam int unsigned TIMEOUT      = 64;
  localparam int          NO_HS        = TIMEOUT;  // hs_delay value meaning "never answer"

  logic        CLK;
  logic        RESET;
  logic        STAGE_VALID;
  logic [2:0]  STAGE_CTRL;
  logic [31:0] STAGE_ADDR;
  logic [47:0] STAGE_ALU;
  logic [3:0]  STAGE_RD;
  logic        STALL;
  logic        MEM_ENABLE;
  logic [2:0]  MEM_CTRL;
  logic [31:0] MEM_ADDRESS;
  logic [47:0] MEM_READ;
  logic        MEM_HANDSHAKE;
  logic        WB_VALID;
  logic        WB_READY;
  logic [47:0] WB_DATA;
  logic [3:0]  WB_RD;
  logic        ERROR;

  mem_stage_ctrl #(
    .SETUP_CYCLES(SETUP_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .STAGE_VALID  (STAGE_VALID),
    .STAGE_CTRL   (STAGE_CTRL),
    .STAGE_ADDR   (STAGE_ADDR),
    .STAGE_ALU    (STAGE_ALU),
    .STAGE_RD     (STAGE_RD),
    .STALL        (STALL),
    .MEM_ENABLE   (MEM_ENABLE),
    .MEM_CTRL     (MEM_CTRL),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READ     (MEM_READ),
    .MEM_HANDSHAKE(MEM_HANDSHAKE),
    .WB_VALID     (WB_VALID),
    .WB_READY     (WB_READY),
    .WB_DATA      (WB_DATA),
    .WB_RD        (WB_RD),
    .ERROR        (ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [47:0] data;
    logic [3:0]  rd;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        exp_error;
  logic [2:0]  last_ctrl;
  logic [31:0] last_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are inspected 1 time unit after the rising edge they come from.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: one pop per writeback presentation, then stability while held.
  logic        presented = 1'b0;
  logic [47:0] held_data;
  logic [3:0]  held_rd;
  exp_t        cur;

  initial begin
    forever begin
      @(negedge CLK);
      if (RESET !== 1'b1) begin
        presented = 1'b0;
      end else if (WB_VALID === 1'b1) begin
        if (!presented) begin
          if (exp_q.size() == 0) begin
            check("wb_unexpected_valid", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            check("wb_data", WB_DATA, cur.data);
            check("wb_rd", WB_RD, cur.rd);
            check("wb_error", ERROR, cur.err);
          end
          presented = 1'b1;
          held_data = WB_DATA;
          held_rd   = WB_RD;
        end else begin
          check("wb_data_stable", WB_DATA, held_data);
          check("wb_rd_stable", WB_RD, held_rd);
        end
        if (WB_READY === 1'b1) presented = 1'b0;
      end
    end
  end

  // One transaction from accept to writeback retirement. hs_delay counts WAIT
  // cycles without HANDSHAKE before it is given; NO_HS means it never comes.
  task automatic do_op(input logic [2:0] ctrl, input logic [31:0] addr,
                       input logic [47:0] alu, input logic [3:0] rd,
                       input logic [47:0] read, input int hs_delay,
                       input int ready_delay);
    exp_t e;
    int   n;
    n = 0;
    while (STALL !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    if (STALL !== 1'b0) begin
      check("idle_wait_bound", STALL, 0);
      return;
    end

    STAGE_VALID = 1'b1;
    STAGE_CTRL  = ctrl;
    STAGE_ADDR  = addr;
    STAGE_ALU   = alu;
    STAGE_RD    = rd;
    WB_READY    = 1'b0;

    e.rd = rd;
    if (!ctrl[2]) begin
      e.data = alu;
    end else if (hs_delay < TIMEOUT) begin
      e.data = read;
    end else begin
      e.data    = '0;
      exp_error = 1'b1;
    end
    e.err = exp_error;
    exp_q.push_back(e);

    step();  // accept edge
    STAGE_VALID = 1'b0;
    STAGE_CTRL  = 3'($urandom());
    STAGE_ADDR  = $urandom();
    STAGE_ALU   = 48'({$urandom(), $urandom()});
    STAGE_RD    = 4'($urandom());
    check("stall_after_accept", STALL, 1);

    if (ctrl[2]) begin
      last_ctrl = ctrl;
      last_addr = addr;
      for (int i = 0; i <= int'(SETUP_CYCLES); i++) begin
        check("enable_low_in_setup", MEM_ENABLE, 0);
        check("addr_setup", MEM_ADDRESS, addr);
        check("ctrl_setup", MEM_CTRL, ctrl);
        MEM_HANDSHAKE = 1'($urandom());
        MEM_READ      = 48'({$urandom(), $urandom()});
        step();
      end
      check("enable_rise", MEM_ENABLE, 1);
      check("wb_valid_low_wait", WB_VALID, 0);
      MEM_HANDSHAKE = 1'b0;
      if (hs_delay < TIMEOUT) begin
        repeat (hs_delay) begin
          step();
          check("enable_held", MEM_ENABLE, 1);
          check("addr_held", MEM_ADDRESS, addr);
        end
        MEM_HANDSHAKE = 1'b1;
        MEM_READ      = read;
        step();
      end else begin
        repeat (TIMEOUT - 1) begin
          step();
          check("enable_held", MEM_ENABLE, 1);
          check("addr_held", MEM_ADDRESS, addr);
        end
        step();
      end
      MEM_HANDSHAKE = 1'($urandom());
      MEM_READ      = 48'({$urandom(), $urandom()});
      check("enable_fall", MEM_ENABLE, 0);
    end
    check("wb_valid_rise", WB_VALID, 1);

    repeat (ready_delay) begin
      step();
      check("stall_in_done", STALL, 1);
      check("wb_valid_hold", WB_VALID, 1);
    end
    WB_READY = 1'b1;
    step();
    WB_READY      = 1'b0;
    MEM_HANDSHAKE = 1'b0;
    check("stall_release", STALL, 0);
    check("wb_valid_fall", WB_VALID, 0);
    check("enable_idle", MEM_ENABLE, 0);
    check("error_flag", ERROR, exp_error);
    check("addr_kept", MEM_ADDRESS, last_addr);
    check("ctrl_kept", MEM_CTRL, last_ctrl);
  endtask

  task automatic random_ops(input int count);
    logic [1:0]  lo;
    logic [2:0]  c;
    int          hd;
    for (int n = 0; n < count; n++) begin
      lo = 2'($urandom_range(0, 3));
      c  = ($urandom_range(0, 3) == 0) ? {1'b0, lo} : {1'b1, lo};
      hd = ($urandom_range(0, 11) == 0) ? NO_HS : int'($urandom_range(0, 6));
      do_op(c, $urandom(), 48'({$urandom(), $urandom()}), 4'($urandom()),
            48'({$urandom(), $urandom()}), hd, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET         = 1'b0;
    STAGE_VALID   = 1'b1;
    STAGE_CTRL    = 3'b100;
    STAGE_ADDR    = 32'hdeadbeef;
    STAGE_ALU     = 48'h0;
    STAGE_RD      = 4'hf;
    MEM_READ      = 48'h5a5a5a5a5a5a;
    MEM_HANDSHAKE = 1'b1;
    WB_READY      = 1'b0;
    exp_error     = 1'b0;
    last_ctrl     = 3'b000;
    last_addr     = 32'h0;

    repeat (4) step();
    check("rst_stall", STALL, 0);
    check("rst_enable", MEM_ENABLE, 0);
    check("rst_wb_valid", WB_VALID, 0);
    check("rst_error", ERROR, 0);
    check("rst_mem_ctrl", MEM_CTRL, 0);
    check("rst_mem_addr", MEM_ADDRESS, 0);
    check("rst_wb_data", WB_DATA, 0);
    check("rst_wb_rd", WB_RD, 0);

    STAGE_VALID   = 1'b0;
    MEM_HANDSHAKE = 1'b0;
    RESET         = 1'b1;
    step();
    check("post_rst_stall", STALL, 0);
    check("post_rst_enable", MEM_ENABLE, 0);

    do_op(3'b100, 32'h00010002, 48'h0, 4'd3, 48'hffffffffffff, 1, 0);
    do_op(3'b111, 32'h00020001, 48'h0, 4'd5, 48'h00b100b300b3, 2, 5);
    do_op(3'b000, 32'h0badf00d, 48'h123456789abc, 4'd7, 48'h0, 0, 1);
    do_op(3'b101, 32'h00030004, 48'h0, 4'd9, 48'h0a0b0c0d0e0f, TIMEOUT - 1, 0);
    do_op(3'b110, 32'h00050006, 48'h0, 4'd2, 48'h111111111111, NO_HS, 2);

    random_ops(16);

    // Reset in the middle of WAIT aborts the op with no writeback.
    STAGE_VALID = 1'b1;
    STAGE_CTRL  = 3'b100;
    STAGE_ADDR  = 32'h00070008;
    STAGE_RD    = 4'd4;
    step();
    STAGE_VALID = 1'b0;
    repeat (SETUP_CYCLES + 1) step();
    check("abort_enable_up", MEM_ENABLE, 1);
    repeat (3) step();
    RESET = 1'b0;
    step();
    RESET     = 1'b1;
    exp_error = 1'b0;
    last_ctrl = 3'b000;
    last_addr = 32'h0;
    check("abort_enable", MEM_ENABLE, 0);
    check("abort_stall", STALL, 0);
    check("abort_wb_valid", WB_VALID, 0);
    check("abort_error", ERROR, 0);
    check("abort_addr", MEM_ADDRESS, 0);
    step();
    check("abort_wb_valid_later", WB_VALID, 0);

    do_op(3'b110, 32'h00090009, 48'h0, 4'd6, 48'h00c0ffee0000, 0, 1);
    random_ops(10);

    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Pipeline memory-stage sequencer that sits directly upstream of memory_access. It accepts one request per transaction from the execute stage and drives ENABLE/CTRL/ADDRESS into memory_access with the required setup and hold. It waits for HANDSHAKE, captures the 48-bit READ word and hands it to writeback with a valid/ready handshake. Non-memory ops bypass memory access, and the block stalls the pipeline while busy.

Parameters:
SETUP_CYCLES, 2, cycles MEM_CTRL/MEM_ADDRESS are held stable before MEM_ENABLE rises (range 1..15)
TIMEOUT, 64, max cycles in WAIT without HANDSHAKE before an error is flagged (range 2..255)

Ports:
CLK  in  1  single pipeline clock; all logic on rising edge
RESET  in  1  synchronous, active-low reset
STAGE_VALID  in  1  execute stage presents an op
STAGE_CTRL  in  3  [2]=memory op, [1]=multiple (3x16b), [0]=picture(1)/kernel(0); 100/110/101/111 valid mem encodings
STAGE_ADDR  in  32  {row[31:16], col[15:0]} memory address
STAGE_ALU  in  48  bypass data for non-memory ops
STAGE_RD  in  4  destination register tag
STALL  out  1  upstream must hold its op
MEM_ENABLE  out  1  to memory_access ENABLE
MEM_CTRL  out  3  to memory_access CTRL
MEM_ADDRESS  out  32  to memory_access ADDRESS
MEM_READ  in  48  from memory_access READ
MEM_HANDSHAKE  in  1  from memory_access HANDSHAKE
WB_VALID  out  1  writeback data valid
WB_READY  in  1  writeback accepts
WB_DATA  out  48  result word
WB_RD  out  4  destination tag
ERROR  out  1  sticky timeout flag

Behaviour:
- Reset (RESET=0 at an edge): state=IDLE; STALL, MEM_ENABLE, WB_VALID, ERROR = 0; MEM_CTRL=3'b000, MEM_ADDRESS=0, WB_DATA=0, WB_RD=0; counters cleared. Reset mid-transaction aborts it: MEM_ENABLE low at the next edge, no WB_VALID.
- States: IDLE, SETUP, WAIT, DONE. STALL = (state != IDLE), registered.
- IDLE: STAGE_VALID=0 → stay.
  - STAGE_VALID & STAGE_CTRL[2]=1 → latch CTRL/ADDR/RD onto MEM_CTRL/MEM_ADDRESS/WB_RD, clear counter, go SETUP.
  - STAGE_VALID & STAGE_CTRL[2]=0 → WB_DATA=STAGE_ALU, WB_RD=STAGE_RD, WB_VALID=1, go DONE (1-cycle bypass latency).
- SETUP: MEM_ENABLE=0, MEM_CTRL/MEM_ADDRESS stable. After SETUP_CYCLES cycles in SETUP, set MEM_ENABLE=1 and go WAIT. A request accepted at edge 0 gives MEM_ENABLE=1 after edge SETUP_CYCLES+1.
- WAIT: MEM_ENABLE=1; MEM_CTRL/MEM_ADDRESS held unchanged for the whole transaction, which is stricter than memory_access's 2-cycle hold. Timeout counter increments each cycle.
  - MEM_HANDSHAKE=1 → WB_DATA=MEM_READ (unmodified 48 bits), WB_VALID=1, MEM_ENABLE=0, go DONE.
  - Counter reaches TIMEOUT with no handshake → ERROR=1 (sticky until reset), WB_DATA=0, WB_VALID=1, MEM_ENABLE=0, go DONE.
  - Handshake and timeout on the same cycle → handshake wins, ERROR unchanged.
- DONE: hold WB_VALID/WB_DATA/WB_RD stable. On WB_READY=1 → WB_VALID=0, go IDLE (STALL low the following cycle). No new op is accepted in DONE.
- MEM_HANDSHAKE outside WAIT is ignored. STAGE_* inputs outside IDLE are ignored.
- After every completed or timed-out memory op, MEM_ENABLE is 0 in DONE and IDLE. MEM_CTRL/MEM_ADDRESS keep their last values until the next accept.

Test Plan:
- Reset held 4 cycles with MEM_HANDSHAKE=1 → all outputs zero, state IDLE; release → STALL=0.
- Kernel single op: CTRL=100, ADDR=32'h00010002, RD=3; memory responds HANDSHAKE with READ=48'hffffffffffff → MEM_ENABLE rises 3 cycles after accept; WB_VALID=1 next cycle after handshake, WB_DATA=48'hffffffffffff, WB_RD=3; MEM_ADDRESS stable throughout.
- Picture multiple op: CTRL=111, ADDR=32'h00020001, READ=48'h00b100b300b3; WB_READY held 0 for 5 cycles → WB_VALID and WB_DATA stay stable, STALL=1; WB_READY=1 → IDLE next cycle.
- Bypass op: CTRL=000, STAGE_ALU=48'h123456789abc → WB_VALID one cycle after accept with that data; MEM_ENABLE never rises.
- Timeout: no HANDSHAKE for TIMEOUT=64 cycles → ERROR=1, WB_DATA=0, WB_VALID=1. Handshake on cycle 64 instead → normal data, ERROR=0.
- Reset asserted in WAIT → MEM_ENABLE=0 and STALL=0 at the next edge, no WB_VALID; a following op completes normally.
